// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RISC-V core.
// Sequences IDLE -> FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK, with
// ready/request handshakes to instruction and data memory, per-opcode write
// enables, sticky illegal-opcode and memory-timeout traps into HALT, and a
// retired-instruction counter.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   run               start/continue execution (sampled in IDLE and WRITEBACK)
//   opcode            instruction opcode, captured in DECODE
//   imem_ready        instruction memory ready
//   dmem_ready        data memory ready
//   imem_req, fetch   instruction fetch request / IR load enable (FETCH)
//   decode, execute   DECODE / EXECUTE phase strobes
//   dmem_req          data memory request (MEM)
//   dm_write_en       data memory write enable (MEM, store only)
//   rf_write_en       register file write enable (WRITEBACK, writing opcodes)
//   pc_write_en       PC update enable (WRITEBACK)
//   finished          instruction retired pulse (WRITEBACK)
//   illegal, timeout  sticky trap flags, cleared only by rst
//   state             current state encoding
//   instr_count       retired instruction count, wrapping
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 fetch,
  output logic                 decode,
  output logic                 execute,
  output logic                 dmem_req,
  output logic                 dm_write_en,
  output logic                 rf_write_en,
  output logic                 pc_write_en,
  output logic                 finished,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMem       = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd7
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT - 1);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OpR, OpI, OpLoad, OpStore, OpBranch,
      OpJal, OpJalr, OpLui, OpAuipc, OpSystem: is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rf(input logic [6:0] op);
    case (op)
      OpR, OpI, OpLoad, OpJal, OpJalr, OpLui, OpAuipc: writes_rf = 1'b1;
      default:                                         writes_rf = 1'b0;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [6:0]           opcode_q, opcode_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 timeout_hit;

  // A zero MEM_TIMEOUT disables trapping; the counter then just free-runs.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WaitMax);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    fetch       = 1'b0;
    decode      = 1'b0;
    execute     = 1'b0;
    dmem_req    = 1'b0;
    dm_write_en = 1'b0;
    rf_write_en = 1'b0;
    pc_write_en = 1'b0;
    finished    = 1'b0;

    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          wait_d  = '0;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        fetch    = 1'b1;
        // Ready in the final allowed cycle still wins over the trap.
        if (imem_ready) begin
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d   = StHalt;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        decode   = 1'b1;
        opcode_d = opcode;
        if (!is_legal(opcode)) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else if (opcode == OpSystem) begin
          state_d = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        execute = 1'b1;
        if (opcode_q == OpLoad || opcode_q == OpStore) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StWriteback;
        end
      end
      StMem: begin
        dmem_req    = 1'b1;
        dm_write_en = (opcode_q == OpStore);
        if (dmem_ready) begin
          state_d = StWriteback;
        end else if (timeout_hit) begin
          state_d   = StHalt;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWriteback: begin
        pc_write_en = 1'b1;
        finished    = 1'b1;
        rf_write_en = writes_rf(opcode_q);
        count_d     = count_q + CNT_WIDTH'(1);
        if (run) begin
          state_d = StFetch;
          wait_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StHalt: begin
        // Parked until reset; flags hold.
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Each instruction is described by
// transaction-level parameters (opcode, fetch stalls, data stalls, run at
// retire); the model expands that into the expected per-cycle output trace.
module tb_multicycle_control_unit;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic          clk;
  logic          rst;
  logic          run;
  logic [6:0]    opcode;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req;
  logic          fetch;
  logic          decode;
  logic          execute;
  logic          dmem_req;
  logic          dm_write_en;
  logic          rf_write_en;
  logic          pc_write_en;
  logic          finished;
  logic          illegal;
  logic          timeout;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_control_unit #(
    .MEM_TIMEOUT(TO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .fetch      (fetch),
    .decode     (decode),
    .execute    (execute),
    .dmem_req   (dmem_req),
    .dm_write_en(dm_write_en),
    .rf_write_en(rf_write_en),
    .pc_write_en(pc_write_en),
    .finished   (finished),
    .illegal    (illegal),
    .timeout    (timeout),
    .state      (state),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs_v;
  assign obs_v = {state, imem_req, fetch, decode, execute, dmem_req, dm_write_en,
                  rf_write_en, pc_write_en, finished, illegal, timeout, instr_count};

  int n_checks = 0;
  int n_err    = 0;

  // Model state.
  bit m_illegal = 0;
  bit m_timeout = 0;
  int m_count   = 0;
  int cur       = 1;  // 0: DUT in FETCH, 1: DUT in IDLE

  logic [6:0] legal_ops [9] = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui,
                                OpAuipc};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic bit op_writes_rf(input logic [6:0] op);
    return op == OpR || op == OpI || op == OpLoad || op == OpJal || op == OpJalr ||
           op == OpLui || op == OpAuipc;
  endfunction

  function automatic bit op_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return op == OpSystem;
  endfunction

  // Expected observation vector for the current cycle.
  function automatic logic [17:0] ev(input int st, input bit ireq, input bit fe, input bit de,
                                     input bit ex, input bit dreq, input bit dwe, input bit rfwe,
                                     input bit pcwe, input bit fin);
    logic [2:0]    s3;
    logic [CW-1:0] c;
    s3 = st[2:0];
    c  = m_count[CW-1:0];
    return {s3, ireq, fe, de, ex, dreq, dwe, rfwe, pcwe, fin, m_illegal, m_timeout, c};
  endfunction

  // One clock: drive inputs at negedge, check the current state's outputs.
  task automatic step(input string tag, input logic [17:0] expv, input bit r,
                      input logic [6:0] op, input bit ir, input bit dr);
    @(negedge clk);
    run        = r;
    opcode     = op;
    imem_ready = ir;
    dmem_ready = dr;
    #1;
    check(tag, {14'b0, obs_v}, {14'b0, expv});
  endtask

  // Reset asserted away from any clock edge; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst        = 1'b1;
    run        = 1'b0;
    opcode     = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    m_illegal  = 0;
    m_timeout  = 0;
    m_count    = 0;
    #1;
    check("rst_async", {14'b0, obs_v}, {14'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    @(negedge clk);
    rst = 1'b0;
    cur = 1;
  endtask

  task automatic idle_to_fetch(input int n);
    for (int i = 0; i < n; i++)
      step("idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, rop(), rb(), rb());
    step("idle_go", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, rop(), rb(), rb());
    cur = 0;
  endtask

  task automatic halt_and_reset();
    for (int i = 0; i < 3; i++)
      step("halt", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, rop(), 1'b1, 1'b1);
    do_reset();
  endtask

  // Starts in FETCH. status: 0 -> next FETCH, 1 -> IDLE, 2 -> HALT.
  task automatic do_instr(input logic [6:0] op, input int istall, input int dstall,
                          input bit run_wb, output int status);
    bit is_mem, is_st, rdy, go;
    int k;
    is_mem = (op == OpLoad) || (op == OpStore);
    is_st  = (op == OpStore);
    status = 0;
    k  = 0;
    go = 1;
    while (go) begin
      rdy = (k >= istall);
      step("fetch", ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), rb(), rop(), rdy, rb());
      if (rdy) go = 0;
      else if (k == TO - 1) begin m_timeout = 1; status = 2; go = 0; end
      else k++;
    end
    if (status == 0) begin
      step("decode", ev(2, 0, 0, 1, 0, 0, 0, 0, 0, 0), rb(), op, rb(), rb());
      if (!op_legal(op)) begin
        m_illegal = 1;
        status    = 2;
      end else if (op == OpSystem) begin
        status = 2;
      end
    end
    if (status == 0) begin
      step("execute", ev(3, 0, 0, 0, 1, 0, 0, 0, 0, 0), rb(), rop(), rb(), rb());
      if (is_mem) begin
        k  = 0;
        go = 1;
        while (go) begin
          rdy = (k >= dstall);
          step("mem", ev(4, 0, 0, 0, 0, 1, is_st, 0, 0, 0), rb(), rop(), rb(), rdy);
          if (rdy) go = 0;
          else if (k == TO - 1) begin m_timeout = 1; status = 2; go = 0; end
          else k++;
        end
      end
    end
    if (status == 0) begin
      step("wb", ev(5, 0, 0, 0, 0, 0, 0, op_writes_rf(op), 1, 1), run_wb, rop(), rb(), rb());
      m_count = (m_count + 1) % (1 << CW);
      status  = run_wb ? 0 : 1;
    end
  endtask

  task automatic run_one(input logic [6:0] op, input int istall, input int dstall,
                         input bit run_wb);
    int s;
    if (cur == 1) idle_to_fetch($urandom_range(0, 2));
    do_instr(op, istall, dstall, run_wb, s);
    cur = s;
    if (s == 2) halt_and_reset();
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    opcode     = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold", {14'b0, obs_v}, {14'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    rst = 1'b0;

    // Directed cases.
    run_one(OpR, 0, 0, 1);
    run_one(OpLoad, 0, 3, 1);
    run_one(OpStore, 1, 2, 1);
    run_one(OpBranch, 0, 0, 0);
    run_one(7'b1111111, 0, 0, 1);   // illegal
    run_one(OpR, 4, 0, 1);          // fetch timeout
    run_one(OpLoad, 3, 3, 1);       // ready on last allowed cycle
    run_one(OpStore, 0, 5, 1);      // mem timeout
    run_one(OpSystem, 0, 0, 1);

    // Reset in the middle of an instruction.
    run_one(OpI, 0, 0, 1);
    step("fetch", ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, rop(), 1'b1, rb());
    step("decode", ev(2, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, OpR, rb(), rb());
    do_reset();
    step("post_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, rop(), 1'b1, 1'b1);

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      int r;
      logic [6:0] op;
      int is, ds;
      r = $urandom_range(0, 17);
      if (r < 16) op = legal_ops[r % 9];
      else if (r == 16) op = OpSystem;
      else op = rop();
      is = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
      ds = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
      run_one(op, is, ds, $urandom_range(0, 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
